moore_seq_detect: RTL and testbench
===================================

MOORE_SEQ_DETECT -- requirements
Module: moore_seq_detect

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011: the target sequence; PATTERN[PAT_W-1] is the first bit received, PATTERN[0] the last.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 clk  input  1: single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1: asynchronous, active-low reset.
REQ-007 in  input  1: serial data bit, sampled on the rising edge when en=1.
REQ-008 en  input  1: sample enable; when low, in is ignored and all state holds.
REQ-009 clear  input  1: synchronous clear of the state and the counter.
REQ-010 out  output  1: Moore match flag, a function of the registered state only.
REQ-011 match_cnt  output  CNT_W: number of matches since reset or clear, saturating.
REQ-012 cnt_sat  output  1: high while match_cnt equals all-ones.

Function
REQ-013 The internal state SHALL be an index S in 0..PAT_W, held in ceil(log2(PAT_W+1)) bits; S = number of leading PATTERN bits currently matched.
REQ-014 On an edge with en=1 and clear=0, the bit history h SHALL be the previous matched prefix (the first S pattern bits, or the overlap-restart prefix if S=PAT_W) followed by in.
REQ-015 On that edge, the next S SHALL be the length of the longest prefix of PATTERN (length at most PAT_W) that is a suffix of h.
REQ-016 When S=PAT_W and OVERLAP=1, the matched prefix used in REQ-014 SHALL be the longest proper prefix of PATTERN that is also a suffix of PATTERN.
REQ-017 When S=PAT_W and OVERLAP=0, the matched prefix used in REQ-014 SHALL be empty, so the next S depends on in alone (1 or 0).
REQ-018 out SHALL be 1 exactly when S=PAT_W; there is no combinational path from in, en or clear to out.
REQ-019 out SHALL assert in the cycle immediately after the edge that consumed the last pattern bit (one-cycle latency), and SHALL stay high for exactly one enabled cycle unless the next edge completes another match.
REQ-020 While en=0, out SHALL hold its value, including holding high if S=PAT_W.
REQ-021 match_cnt SHALL increment by 1 on each edge where the next S equals PAT_W and en=1.
REQ-022 match_cnt SHALL saturate at 2^CNT_W-1, with no wrap-around.
REQ-023 clear=1 SHALL set S=0 and match_cnt=0 on the next edge, has priority over en and in, and SHALL NOT count a match on that edge.
REQ-024 Any unreachable encoding of S (greater than PAT_W) SHALL transition to 0 on the next enabled edge, and out SHALL be 0 while in it.

Reset
REQ-025 reset_n=0 SHALL immediately force S=0, out=0, match_cnt=0 and cnt_sat=0, independent of clk.
REQ-026 Reset asserted mid-sequence SHALL discard all partial-match history; the first enabled edge after deassertion is treated as bit 1 of a new stream.

Verification
REQ-027 Defaults, OVERLAP=1, in stream 1,0,1,1,0,1,1 with en=1 -> out high in the cycles after bits 4 and 7; match_cnt=2.
REQ-028 Same stream with OVERLAP=0 -> out high only after bit 4; match_cnt=1.
REQ-029 Stream 1,0,1 then en=0 for 3 cycles with in toggling, then in=1 with en=1 -> no out during the en-low cycles; out high after the final bit; match_cnt=1.
REQ-030 CNT_W=2, repeated PATTERN for 5 matches -> match_cnt goes 1,2,3,3,3; cnt_sat=1 from the third match onward.
REQ-031 Stream 1,0,1 then reset_n pulsed low asynchronously between edges, then 1 -> no match; out=0; match_cnt=0.
REQ-032 Stream 1,0,1 then clear=1 with in=1 -> S=0, match_cnt=0, out stays 0; next stream 1,0,1,1 -> out high after bit 4.

Source files
------------

// File: rtl/moore_seq_detect.sv
// moore_seq_detect: Moore detector of PATTERN on serial in (clk, reset_n, in, en, clear) -> out flag, saturating match_cnt, cnt_sat
module moore_seq_detect #(
  parameter int PAT_W = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in,
  input  logic             en,
  input  logic             clear,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);
  localparam int SW = $clog2(PAT_W + 1);
  localparam logic [SW-1:0] FULL = SW'(PAT_W);
  function automatic int border();
    int r;
    logic ok;
    r = 0;
    for (int k = 1; k < PAT_W; k++) begin
      ok = 1'b1;
      for (int i = 0; i < PAT_W; i++)
        if (i < k && PATTERN[PAT_W-1-i] != PATTERN[k-1-i]) ok = 1'b0;
      if (ok) r = k;
    end
    return r;
  endfunction
  function automatic int trans(int s, logic b);
    int best;
    int j;
    logic ok;
    logic hb;
    best = 0;
    for (int k = 1; k <= PAT_W; k++) begin
      ok = k <= s + 1;
      for (int i = 0; i < PAT_W; i++)
        if (ok && i < k) begin
          j = s + 1 - k + i;
          hb = j == s ? b : PATTERN[PAT_W-1-j];
          if (hb != PATTERN[PAT_W-1-i]) ok = 1'b0;
        end
      if (ok) best = k;
    end
    return best;
  endfunction
  localparam int RESTART = OVERLAP ? border() : 0;
  logic [SW-1:0] t0 [2**SW];
  logic [SW-1:0] t1 [2**SW];
  for (genvar g = 0; g < 2**SW; g++) begin : g_tbl
    // full match restarts from the overlap prefix; unreachable encodings fall to 0
    localparam int S = g == PAT_W ? RESTART : (g > PAT_W ? 0 : g);
    assign t0[g] = g > PAT_W ? '0 : SW'(trans(S, 1'b0));
    assign t1[g] = g > PAT_W ? '0 : SW'(trans(S, 1'b1));
  end
  logic [SW-1:0] state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= '0;
      match_cnt <= '0;
    end else begin
      state <= state_nxt;
      match_cnt <= cnt_nxt;
    end
  always_comb begin
    state_nxt = clear ? '0 : en ? (in ? t1[state] : t0[state]) : state;
    cnt_nxt = clear ? '0 : (en && state_nxt == FULL && !cnt_sat) ? match_cnt + 1'b1 : match_cnt;
  end
  always_comb begin
    out = state == FULL;
    cnt_sat = &match_cnt;
  end
endmodule

// File: tb/tb_moore_seq_detect.sv
// tb_moore_seq_detect: scoreboard bench over overlapping, non-overlapping and narrow-counter instances
module tb_moore_seq_detect;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in = 1'b0;
  logic en = 1'b0;
  logic clear = 1'b0;
  logic out_a, out_b, out_c, sat_a, sat_b, sat_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  always #5 clk = ~clk;
  moore_seq_detect #(.OVERLAP(1'b1)) u_a (.clk(clk), .reset_n(reset_n), .in(in), .en(en), .clear(clear), .out(out_a), .match_cnt(cnt_a), .cnt_sat(sat_a));
  moore_seq_detect #(.OVERLAP(1'b0)) u_b (.clk(clk), .reset_n(reset_n), .in(in), .en(en), .clear(clear), .out(out_b), .match_cnt(cnt_b), .cnt_sat(sat_b));
  moore_seq_detect #(.CNT_W(2)) u_c (.clk(clk), .reset_n(reset_n), .in(in), .en(en), .clear(clear), .out(out_c), .match_cnt(cnt_c), .cnt_sat(sat_c));
  typedef struct {
    logic [2:0] out;
    logic [7:0] ca;
    logic [7:0] cb;
    logic [1:0] cc;
    logic sa;
    logic sc;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  logic [3:0] hist [3];
  int n [3];
  logic mo [3];
  int mc [3];
  int mx [3] = '{255, 255, 3};
  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i] = '0;
      n[i] = 0;
      mo[i] = 1'b0;
      mc[i] = 0;
    end
  endtask
  task automatic model_step(logic b);
    for (int i = 0; i < 3; i++) begin
      hist[i] = {hist[i][2:0], b};
      if (n[i] < 16) n[i]++;
      mo[i] = n[i] >= 4 && hist[i] == 4'b1011;
      if (mo[i]) begin
        if (mc[i] < mx[i]) mc[i]++;
        if (i == 1) n[i] = 0;
      end
    end
  endtask
  task automatic push_exp();
    exp_t e;
    e.out = {mo[2], mo[1], mo[0]};
    e.ca = 8'(mc[0]);
    e.cb = 8'(mc[1]);
    e.cc = 2'(mc[2]);
    e.sa = mc[0] == 255;
    e.sc = mc[2] == 3;
    q.push_back(e);
  endtask
  task automatic chk(string tag, logic [7:0] act, logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic compare(string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = q.pop_front();
    chk({tag, ".out"}, {5'b0, out_c, out_b, out_a}, {5'b0, e.out});
    chk({tag, ".cnt_a"}, cnt_a, e.ca);
    chk({tag, ".cnt_b"}, cnt_b, e.cb);
    chk({tag, ".cnt_c"}, {6'b0, cnt_c}, {6'b0, e.cc});
    chk({tag, ".sat_a"}, {7'b0, sat_a}, {7'b0, e.sa});
    chk({tag, ".sat_c"}, {7'b0, sat_c}, {7'b0, e.sc});
    chk({tag, ".sat_b"}, {7'b0, sat_b}, {7'b0, e.cb == 8'hff});
  endtask
  task automatic step(logic b, logic e_, logic c, string tag);
    in = b;
    en = e_;
    clear = c;
    if (c) model_reset();
    else if (e_) model_step(b);
    push_exp();
    @(negedge clk);
    compare(tag);
  endtask
  task automatic areset(string tag);
    en = 1'b0;
    clear = 1'b0;
    reset_n = 1'b0;
    model_reset();
    push_exp();
    #1;
    compare(tag);
    #1 reset_n = 1'b1;
  endtask
  task automatic bits(logic [3:0] v, int cnt, string tag);
    for (int i = cnt - 1; i >= 0; i--) step(v[i], 1'b1, 1'b0, tag);
  endtask
  initial begin
    model_reset();
    areset("reset");
    @(negedge clk);
    bits(4'b1011, 4, "s027a");
    bits(4'b0110, 3, "s027b");
    step(1'b0, 1'b0, 1'b0, "hold_hi0");
    step(1'b1, 1'b0, 1'b0, "hold_hi1");
    step(1'b1, 1'b1, 1'b1, "clear0");
    bits(4'b0101, 3, "s029a");
    step(1'b0, 1'b0, 1'b0, "s029_en0");
    step(1'b1, 1'b0, 1'b0, "s029_en1");
    step(1'b0, 1'b0, 1'b0, "s029_en2");
    step(1'b1, 1'b1, 1'b0, "s029_last");
    step(1'b0, 1'b1, 1'b1, "clear1");
    bits(4'b0101, 3, "s032a");
    step(1'b1, 1'b1, 1'b1, "s032_clr");
    bits(4'b1011, 4, "s032b");
    step(1'b1, 1'b0, 1'b1, "clr_prio");
    bits(4'b0101, 3, "s031a");
    areset("s031_rst");
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, "s031_after");
    step(1'b0, 1'b1, 1'b1, "clear2");
    for (int m = 0; m < 5; m++) bits(4'b1011, 4, "s030");
    step(1'b1, 1'b1, 1'b0, "tail");
    checks++;
    assert (q.size() === 0) else begin
      failures++;
      $error("FAIL drain: got %0d expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
